mole_round_ctrl: RTL

Game sequencer for the whack-a-mole design. Each round it pulls a fresh value from the 6-bit LFSR random generator and lights one mole LED on `dispL`. It then waits a bounded window for the matching button and keeps score, hit/miss and round counters. Those counters feed the 7-segment display driver.

---
 rtl/mole_round_ctrl_pkg.sv | 13 +
 rtl/mole_round_ctrl_if.sv | 22 ++
 rtl/mole_round_ctrl_timer.sv | 28 ++
 rtl/mole_round_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/mole_round_ctrl_pkg.sv
// mole_round_ctrl_pkg: shared states, widths and defaults for the whack-a-mole sequencer
package mole_round_ctrl_pkg;
   localparam int NUM_MOLES = 8;
   localparam int CNT_W = 6;
   localparam int RAND_W = 6;
   localparam int DEF_TICK_DIV = 50000;
   localparam int DEF_MOLE_TICKS = 800;
   localparam int DEF_GAP_TICKS = 300;
   typedef enum logic [2:0] {IDLE, GAP, SHOW, RESULT, DONE} state_t;
   function automatic logic [2:0] pick_mole(input logic [2:0] r, input logic [2:0] last);
      return (r == last) ? r + 3'd1 : r;
   endfunction
endpackage

// File: rtl/mole_round_ctrl_if.sv
// mole_round_ctrl_if: game-side signal bundle between the sequencer and its surroundings
interface mole_round_ctrl_if;
   import mole_round_ctrl_pkg::*;
   logic start;
   logic [NUM_MOLES-1:0] button;
   logic [RAND_W-1:0] rand_val;
   logic rand_req;
   logic [NUM_MOLES-1:0] dispL;
   logic [CNT_W-1:0] score;
   logic [CNT_W-1:0] misses;
   logic [CNT_W-1:0] round_cnt;
   logic busy;
   logic game_over;
   modport master (
      output start, button, rand_val,
      input rand_req, dispL, score, misses, round_cnt, busy, game_over
   );
   modport slave (
      input start, button, rand_val,
      output rand_req, dispL, score, misses, round_cnt, busy, game_over
   );
endinterface

// File: rtl/mole_round_ctrl_timer.sv
// game_tick_timer: tick divider plus tick counter, flags the last cycle of a target-tick window
module game_tick_timer #(
   parameter int TICK_DIV = 4,
   parameter int W = 4
) (
   input logic clk,
   input logic reset,
   input logic restart,
   input logic [W-1:0] target,
   output logic expired
);
   localparam int DW = $clog2(TICK_DIV);
   logic [DW-1:0] div_q;
   logic [W-1:0] tick_q;
   logic wrap;
   assign wrap = div_q == DW'(TICK_DIV - 1);
   assign expired = wrap && (tick_q == target - W'(1));
   // Divide the clock into ticks and count ticks since the last restart.
   always_ff @(posedge clk) begin
      if (!reset || restart) begin
         div_q <= '0;
         tick_q <= '0;
      end else begin
         div_q <= wrap ? '0 : div_q + DW'(1);
         tick_q <= wrap ? tick_q + W'(1) : tick_q;
      end
   end
endmodule

// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl: whack-a-mole round sequencer with mole selection, edge detect and scoring
module mole_round_ctrl
   import mole_round_ctrl_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int MOLE_TICKS = DEF_MOLE_TICKS,
   parameter int GAP_TICKS = DEF_GAP_TICKS,
   parameter int ROUNDS = 30
) (
   input logic clk,
   input logic reset,
   mole_round_ctrl_if.slave bus
);
   localparam int MAX_T = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
   localparam int TW = $clog2(MAX_T + 1);
   state_t state_q, state_d;
   logic [NUM_MOLES-1:0] button_q, press, mole_bit;
   logic [2:0] mole_q, mole_d;
   logic [CNT_W-1:0] score_q, misses_q, round_q;
   logic hit_q, hit_d, req_q, req_d, clear, expired, wrong, right;
   logic [TW-1:0] target;
   logic unused_rand;
   assign unused_rand = ^bus.rand_val[RAND_W-1:3];
   assign press = bus.button & ~button_q;
   assign mole_bit = NUM_MOLES'(1) << mole_q;
   assign wrong = |(press & ~mole_bit);
   assign right = |(press & mole_bit);
   assign target = TW'(state_q == GAP ? GAP_TICKS : MOLE_TICKS);
   game_tick_timer #(.TICK_DIV(TICK_DIV), .W(TW)) u_timer (
      .clk(clk),
      .reset(reset),
      .restart(state_d != state_q),
      .target(target),
      .expired(expired)
   );
   // Next state; mole_q doubles as last_idx since both latch the same value.
   always_comb begin
      state_d = state_q;
      mole_d = mole_q;
      hit_d = hit_q;
      req_d = 1'b0;
      clear = 1'b0;
      case (state_q)
         IDLE, DONE: if (bus.start) begin
            state_d = GAP;
            req_d = 1'b1;
            clear = 1'b1;
         end
         GAP: if (expired) begin
            state_d = SHOW;
            mole_d = pick_mole(bus.rand_val[2:0], mole_q);
         end
         SHOW: if (wrong || right || expired) begin
            state_d = RESULT;
            hit_d = right && !wrong;
         end
         RESULT: begin
            state_d = (round_q + 1'b1 == CNT_W'(ROUNDS)) ? DONE : GAP;
            req_d = state_d == GAP;
         end
         default: state_d = IDLE;
      endcase
   end
   // State, outcome and saturating counters; button history tracks even through reset.
   always_ff @(posedge clk) begin
      button_q <= bus.button;
      if (!reset) begin
         state_q <= IDLE;
         mole_q <= '0;
         hit_q <= 1'b0;
         req_q <= 1'b0;
         score_q <= '0;
         misses_q <= '0;
         round_q <= '0;
      end else begin
         state_q <= state_d;
         mole_q <= mole_d;
         hit_q <= hit_d;
         req_q <= req_d;
         if (clear) begin
            score_q <= '0;
            misses_q <= '0;
            round_q <= '0;
         end else if (state_q == RESULT) begin
            score_q <= (hit_q && !(&score_q)) ? score_q + 1'b1 : score_q;
            misses_q <= (!hit_q && !(&misses_q)) ? misses_q + 1'b1 : misses_q;
            round_q <= round_q + 1'b1;
         end
      end
   end
   assign bus.rand_req = req_q;
   assign bus.dispL = (state_q == SHOW) ? mole_bit : (state_q == DONE) ? '1 : '0;
   assign bus.score = score_q;
   assign bus.misses = misses_q;
   assign bus.round_cnt = round_q;
   assign bus.busy = (state_q == GAP) || (state_q == SHOW) || (state_q == RESULT);
   assign bus.game_over = state_q == DONE;
endmodule
